// File: rtl/eu_iqueue_banked.sv
// eu_iqueue_banked: in-order issue queue for one execution unit.
// Entries are spread round-robin over NUM_BANKS single-write FIFO banks, so a
// dispatch batch of up to DISPATCH_WIDTH entries lands in distinct banks in a
// single cycle. Global order is kept by reading the banks in the same
// round-robin sequence. The head entry is presented combinationally (fall-through).
module eu_iqueue_banked #(
    parameter int NUM_BANKS       = 4,
    parameter int LOG2_BANK_DEPTH = 4,
    parameter int DISPATCH_WIDTH  = 4,
    parameter int ENTRY_WIDTH     = 64,
    parameter int EUIDX_WIDTH     = 2,
    parameter int EU_IDX          = 0,
    localparam int CAPACITY       = NUM_BANKS * (2 ** LOG2_BANK_DEPTH),
    localparam int OCC_W          = $clog2(CAPACITY + 1)
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [DISPATCH_WIDTH*ENTRY_WIDTH-1:0] disp_entry_i,
    input  logic [DISPATCH_WIDTH-1:0]             disp_valid_i,
    input  logic [DISPATCH_WIDTH*EUIDX_WIDTH-1:0] disp_euidx_i,
    output logic                                  disp_stall_o,
    input  logic                                  flush_i,
    output logic [ENTRY_WIDTH-1:0]                out_entry_o,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [OCC_W-1:0]                      occupancy_o,
    output logic [OCC_W-1:0]                      free_o,
    output logic                                  full_o,
    output logic                                  empty_o
);

    localparam int BANK_W  = $clog2(NUM_BANKS);
    localparam int DEPTH   = 2 ** LOG2_BANK_DEPTH;
    localparam int DEPTH_W = LOG2_BANK_DEPTH;
    localparam logic [OCC_W-1:0] CAP_V = OCC_W'(CAPACITY);

    // A batch must never need two writes into the same bank in one cycle.
    if (DISPATCH_WIDTH > NUM_BANKS || DISPATCH_WIDTH < 1) begin : g_bad_dispatch_width
        $error("eu_iqueue_banked: DISPATCH_WIDTH must be in 1..NUM_BANKS");
    end
    if (NUM_BANKS < 2 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_num_banks
        $error("eu_iqueue_banked: NUM_BANKS must be a power of 2 and >= 2");
    end
    if (LOG2_BANK_DEPTH < 1) begin : g_bad_depth
        $error("eu_iqueue_banked: LOG2_BANK_DEPTH must be >= 1");
    end

    logic [BANK_W-1:0]      wr_bank_ptr_q, wr_bank_ptr_d;
    logic [BANK_W-1:0]      rd_bank_ptr_q, rd_bank_ptr_d;
    logic [DEPTH_W-1:0]     head_q [NUM_BANKS];
    logic [DEPTH_W-1:0]     head_d [NUM_BANKS];
    logic [DEPTH_W-1:0]     tail_q [NUM_BANKS];
    logic [DEPTH_W-1:0]     tail_d [NUM_BANKS];
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic [ENTRY_WIDTH-1:0] mem_q [NUM_BANKS][DEPTH];

    logic [DISPATCH_WIDTH-1:0] lane_rel;
    logic [OCC_W-1:0]          lane_off [DISPATCH_WIDTH];
    logic [OCC_W-1:0]          n_rel;
    logic [NUM_BANKS-1:0]      bank_we;
    logic [ENTRY_WIDTH-1:0]    bank_wdata [NUM_BANKS];
    logic [BANK_W-1:0]         bank_idx;
    logic [OCC_W-1:0]          free;
    logic                      stall;
    logic                      accept;
    logic                      pop;
    logic                      empty;

    // Status derived from the registered occupancy (pre-pop view).
    assign free   = CAP_V - occ_q;
    assign empty  = (occ_q == '0);
    assign stall  = (n_rel > free) & ~flush_i;
    assign accept = ~stall & ~flush_i;
    assign pop    = ~empty & out_ready_i & ~flush_i;

    // Select lanes targeting this EU and give each its rank among them.
    always_comb begin
        n_rel    = '0;
        lane_rel = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            lane_rel[k] = disp_valid_i[k] &
                          (disp_euidx_i[k*EUIDX_WIDTH +: EUIDX_WIDTH] == EUIDX_WIDTH'(EU_IDX));
            lane_off[k] = n_rel;
            if (lane_rel[k]) begin
                n_rel = n_rel + OCC_W'(1);
            end
        end
    end

    // Steer the j-th relevant lane to bank (wr_bank_ptr + j) when the batch is accepted.
    always_comb begin
        bank_we  = '0;
        bank_idx = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_wdata[b] = '0;
        end
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            if (lane_rel[k] && accept) begin
                bank_idx             = wr_bank_ptr_q + lane_off[k][BANK_W-1:0];
                bank_we[bank_idx]    = 1'b1;
                bank_wdata[bank_idx] = disp_entry_i[k*ENTRY_WIDTH +: ENTRY_WIDTH];
            end
        end
    end

    // Next-state for bank pointers and occupancy; flush overrides push and pop.
    always_comb begin
        wr_bank_ptr_d = wr_bank_ptr_q;
        rd_bank_ptr_d = rd_bank_ptr_q;
        occ_d         = occ_q;
        head_d        = head_q;
        tail_d        = tail_q;
        if (flush_i) begin
            wr_bank_ptr_d = '0;
            rd_bank_ptr_d = '0;
            occ_d         = '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                head_d[b] = '0;
                tail_d[b] = '0;
            end
        end else begin
            if (accept) begin
                wr_bank_ptr_d = wr_bank_ptr_q + n_rel[BANK_W-1:0];
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (bank_we[b]) begin
                    tail_d[b] = tail_q[b] + DEPTH_W'(1);
                end
            end
            if (pop) begin
                head_d[rd_bank_ptr_q] = head_q[rd_bank_ptr_q] + DEPTH_W'(1);
                rd_bank_ptr_d         = rd_bank_ptr_q + BANK_W'(1);
            end
            occ_d = occ_q + (accept ? n_rel : '0) - OCC_W'(pop);
        end
    end

    // Control state; reset clears the queue asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank_ptr_q <= '0;
            rd_bank_ptr_q <= '0;
            occ_q         <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                head_q[b] <= '0;
                tail_q[b] <= '0;
            end
        end else begin
            wr_bank_ptr_q <= wr_bank_ptr_d;
            rd_bank_ptr_q <= rd_bank_ptr_d;
            occ_q         <= occ_d;
            for (int b = 0; b < NUM_BANKS; b++) begin
                head_q[b] <= head_d[b];
                tail_q[b] <= tail_d[b];
            end
        end
    end

    // Entry storage: written at each bank's tail, never reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_we[b]) begin
                mem_q[b][tail_q[b]] <= bank_wdata[b];
            end
        end
    end

    assign out_entry_o  = mem_q[rd_bank_ptr_q][head_q[rd_bank_ptr_q]];
    assign out_valid_o  = ~empty;
    assign empty_o      = empty;
    assign full_o       = (occ_q == CAP_V);
    assign occupancy_o  = occ_q;
    assign free_o       = free;
    assign disp_stall_o = stall;

endmodule

// File: tb/tb_eu_iqueue_banked.sv
// Directed bench for eu_iqueue_banked: 4 banks x 4 entries, 4 lanes, EU index 2.
module tb_eu_iqueue_banked;

    localparam int NB  = 4;
    localparam int L2D = 2;
    localparam int DW  = 4;
    localparam int EW  = 16;
    localparam int EUW = 2;
    localparam int EUI = 2;
    localparam int OW  = 5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DW*EW-1:0]  disp_entry;
    logic [DW-1:0]     disp_valid;
    logic [DW*EUW-1:0] disp_euidx;
    logic              disp_stall;
    logic              flush;
    logic [EW-1:0]     out_entry;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     occupancy;
    logic [OW-1:0]     free;
    logic              full;
    logic              empty;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    eu_iqueue_banked #(
        .NUM_BANKS(NB), .LOG2_BANK_DEPTH(L2D), .DISPATCH_WIDTH(DW),
        .ENTRY_WIDTH(EW), .EUIDX_WIDTH(EUW), .EU_IDX(EUI)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .disp_entry_i(disp_entry), .disp_valid_i(disp_valid), .disp_euidx_i(disp_euidx),
        .disp_stall_o(disp_stall), .flush_i(flush),
        .out_entry_o(out_entry), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .occupancy_o(occupancy), .free_o(free), .full_o(full), .empty_o(empty)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = '0;
        disp_euidx = '0;
        disp_entry = '0;
        flush      = 1'b0;
        out_ready  = 1'b0;
    endtask

    // Lanes 0..n-1 valid and aimed at this EU, payload base+k on lane k.
    task automatic push_n(input int n, input logic [15:0] base);
        disp_valid = '0;
        for (int k = 0; k < DW; k++) begin
            disp_euidx[k*EUW +: EUW] = EUW'(EUI);
            disp_entry[k*EW +: EW]   = base + 16'(k);
            if (k < n) disp_valid[k] = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        reset_n = 1'b0;
        #12;
        chk("rst_occ",   occupancy, 0);
        chk("rst_free",  free, 16);
        chk("rst_empty", empty, 1);
        chk("rst_full",  full, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_stall", disp_stall, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Ready while empty does nothing
        out_ready = 1'b1;
        tick();
        tick();
        chk("ready_empty_occ", occupancy, 0);
        chk("ready_empty_valid", out_valid, 0);
        idle();

        // Mixed-EU batch: only lanes 0,2,3 belong here
        disp_valid = 4'hF;
        disp_euidx = 8'hA6;
        disp_entry = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        #1 chk("mix_stall", disp_stall, 0);
        tick();
        idle();
        #1;
        chk("mix_occ", occupancy, 3);
        chk("mix_pop0", out_entry, 16'hAAAA);
        out_ready = 1'b1;
        tick();
        chk("mix_pop1", out_entry, 16'hCCCC);
        tick();
        chk("mix_pop2", out_entry, 16'hDDDD);
        tick();
        out_ready = 1'b0;
        chk("mix_drained", empty, 1);

        // Fill to 14, oversized batch stalls, smaller retry fills the queue
        push_n(4, 16'h0100); tick();
        push_n(4, 16'h0104); tick();
        push_n(4, 16'h0108); tick();
        push_n(2, 16'h010C); tick();
        idle();
        #1 chk("fill_occ14", occupancy, 14);
        push_n(3, 16'h0200);
        #1 chk("fill_stall", disp_stall, 1);
        tick();
        idle();
        #1 chk("fill_stall_occ", occupancy, 14);
        push_n(2, 16'h010E);
        #1 chk("fill_retry_stall", disp_stall, 0);
        tick();
        idle();
        #1;
        chk("full_occ",  occupancy, 16);
        chk("full_flag", full, 1);
        chk("full_free", free, 0);
        chk("full_head", out_entry, 16'h0100);

        // Full plus pop: pop does not make room the same cycle
        out_ready = 1'b1;
        push_n(1, 16'h0300);
        #1 chk("fullpop_stall", disp_stall, 1);
        tick();
        chk("fullpop_occ", occupancy, 15);
        chk("fullpop_head", out_entry, 16'h0101);
        chk("fullpop_retry_stall", disp_stall, 0);
        tick();
        chk("pushpop_occ", occupancy, 15);
        chk("pushpop_head", out_entry, 16'h0102);

        // Flush wins over an otherwise-stalling batch and a pop
        push_n(4, 16'h0400);
        flush = 1'b1;
        #1 chk("flush_stall", disp_stall, 0);
        tick();
        idle();
        #1;
        chk("flush_occ", occupancy, 0);
        chk("flush_empty", empty, 1);

        // Streaming one in, one out across bank and pointer wrap
        for (int i = 0; i <= 40; i++) begin
            if (i < 40) push_n(1, 16'h5000 + 16'(i));
            else disp_valid = '0;
            out_ready = 1'b1;
            if (i > 0) begin
                chk("stream_order", out_entry, 16'h5000 + 16'(i - 1));
                chk("stream_occ", occupancy, 1);
            end
            tick();
        end
        idle();
        #1 chk("stream_end_occ", occupancy, 0);

        // Flush at occupancy 7 with a full batch: nothing written
        push_n(4, 16'h0600); tick();
        push_n(3, 16'h0604); tick();
        idle();
        #1 chk("fl7_occ", occupancy, 7);
        push_n(4, 16'h0700);
        flush = 1'b1;
        tick();
        idle();
        #1;
        chk("fl7_after_occ", occupancy, 0);
        chk("fl7_after_empty", empty, 1);
        push_n(1, 16'h0800);
        tick();
        idle();
        #1;
        chk("fl7_next_occ", occupancy, 1);
        chk("fl7_next_head", out_entry, 16'h0800);
        out_ready = 1'b1;
        tick();
        idle();

        // Asynchronous reset mid-cycle at occupancy 5
        push_n(4, 16'h0900); tick();
        push_n(1, 16'h0904); tick();
        idle();
        #1;
        chk("ar_occ5", occupancy, 5);
        chk("ar_valid_pre", out_valid, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_occ", occupancy, 0);
        chk("ar_free", free, 16);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("ar_after_occ", occupancy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
